// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - Load/store unit shared constants, FSM state type and size helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SECOND = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic f3_valid(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_valid = 1'b1;
            default:                        f3_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            default: size_bytes = 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - Byte-lane mask, store-data shift and load-data extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic        op_valid,
    output logic        crosses,
    output logic [3:0]  mask_lo,
    output logic [3:0]  mask_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] ext_rdata
);

    logic [7:0]  mask_wide;
    logic [63:0] wdata_wide;
    logic [31:0] rd_sh;
    logic [5:0]  sh;

    always_comb begin
        op_valid = f3_valid(funct3);
        crosses  = op_valid && (({2'b00, offset} + size_bytes(funct3)) > 4'd4);
        sh       = {1'b0, offset, 3'b000};

        // Lanes beyond byte 3 spill into the next word for the high access.
        mask_wide  = {4'b0000, size_mask(funct3)} << offset;
        mask_lo    = mask_wide[3:0];
        mask_hi    = mask_wide[7:4];
        wdata_wide = {32'h0, wdata} << sh;
        wdata_lo   = wdata_wide[31:0];
        wdata_hi   = wdata_wide[63:32];

        rd_sh = 32'({rdata_hi, rdata_lo} >> sh);
        case (funct3)
            F3_B:    ext_rdata = {{24{rd_sh[7]}}, rd_sh[7:0]};
            F3_H:    ext_rdata = {{16{rd_sh[15]}}, rd_sh[15:0]};
            F3_BU:   ext_rdata = {24'h0, rd_sh[7:0]};
            F3_HU:   ext_rdata = {16'h0, rd_sh[15:0]};
            default: ext_rdata = rd_sh;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - Load/store sequencer splitting misaligned accesses into two word cycles.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        mem_load,
    output logic        mem_store,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [31:0] lo_q;

    logic        op_valid, crosses;
    logic [3:0]  mask_lo, mask_hi;
    logic [31:0] wdata_lo, wdata_hi, ext_rdata;
    logic [31:0] rd_lo, rd_hi, base_addr;

    // Request inputs are held by stall, so the crossing decision is recomputed every cycle.
    assign rd_lo     = crosses ? lo_q : mem_rdata;
    assign rd_hi     = crosses ? mem_rdata : 32'h0;
    assign base_addr = {req_addr[31:2], 2'b00};

    lsu_align u_align (
        .funct3    (req_funct3),
        .offset    (req_addr[1:0]),
        .wdata     (req_wdata),
        .rdata_lo  (rd_lo),
        .rdata_hi  (rd_hi),
        .op_valid  (op_valid),
        .crosses   (crosses),
        .mask_lo   (mask_lo),
        .mask_hi   (mask_hi),
        .wdata_lo  (wdata_lo),
        .wdata_hi  (wdata_hi),
        .ext_rdata (ext_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lo_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_SECOND) lo_q <= mem_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        mem_load  = 1'b0;
        mem_store = 1'b0;
        mem_mask  = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && op_valid) begin
                    mem_load  = !req_store;
                    mem_store = req_store;
                    mem_mask  = mask_lo;
                    mem_addr  = base_addr;
                    mem_wdata = wdata_lo;
                    if (crosses) begin
                        stall   = 1'b1;
                        state_d = ST_SECOND;
                    end else if (!req_store) begin
                        stall   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_SECOND: begin
                mem_load  = !req_store;
                mem_store = req_store;
                mem_mask  = mask_hi;
                mem_addr  = base_addr + 32'd4;
                mem_wdata = wdata_hi;
                stall     = !req_store;
                state_d   = req_store ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = ext_rdata;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are quiet for the whole reset interval, not just after the first edge.
        if (rst) begin
            stall     = 1'b0;
            rsp_valid = 1'b0;
            rsp_rdata = 32'h0;
            mem_load  = 1'b0;
            mem_store = 1'b0;
            mem_mask  = 4'h0;
            mem_addr  = 32'h0;
            mem_wdata = 32'h0;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - Directed self-checking bench for lsu_ctrl.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_load;
    logic        mem_store;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .mem_mask   (mem_mask),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = v;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic chk_idle_port(input string tag);
        chk({tag, "_load"},  {31'h0, mem_load},  32'h0);
        chk({tag, "_store"}, {31'h0, mem_store}, 32'h0);
        chk({tag, "_mask"},  {28'h0, mem_mask},  32'h0);
        chk({tag, "_addr"},  mem_addr,           32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        mem_rdata = 32'h0;
        drive(1'b1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        #1;
        chk_idle_port("rst");
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_rspv",  {31'h0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        step();
        rst = 1'b0;

        // SW aligned: single zero-wait cycle
        #1;
        chk("sw_store", {31'h0, mem_store}, 32'h1);
        chk("sw_load",  {31'h0, mem_load},  32'h0);
        chk("sw_mask",  {28'h0, mem_mask},  32'hF);
        chk("sw_addr",  mem_addr,           32'h100);
        chk("sw_wdata", mem_wdata,          32'hDEADBEEF);
        chk("sw_stall", {31'h0, stall},     32'h0);
        step();
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        chk_idle_port("idle");
        chk("idle_stall", {31'h0, stall}, 32'h0);

        // LBU 0x103
        drive(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
        #1;
        chk("lbu_load",  {31'h0, mem_load},  32'h1);
        chk("lbu_addr",  mem_addr,           32'h100);
        chk("lbu_mask",  {28'h0, mem_mask},  32'h8);
        chk("lbu_stall", {31'h0, stall},     32'h1);
        chk("lbu_rspv0", {31'h0, rsp_valid}, 32'h0);
        chk("lbu_rd0",   rsp_rdata,          32'h0);
        step();
        mem_rdata = 32'h80FF1234;
        #1;
        chk("lbu_rspv",  {31'h0, rsp_valid}, 32'h1);
        chk("lbu_rdata", rsp_rdata,          32'h00000080);
        chk("lbu_rstall",{31'h0, stall},     32'h0);
        chk("lbu_rload", {31'h0, mem_load},  32'h0);
        step();

        // LB same address
        req_funct3 = 3'b000;
        mem_rdata  = 32'h0;
        #1;
        chk("lb_load",  {31'h0, mem_load}, 32'h1);
        chk("lb_stall", {31'h0, stall},    32'h1);
        step();
        mem_rdata = 32'h80FF1234;
        #1;
        chk("lb_rspv",  {31'h0, rsp_valid}, 32'h1);
        chk("lb_rdata", rsp_rdata,          32'hFFFFFF80);
        step();

        // LH 0x101 non-crossing, sign-extended
        drive(1'b1, 1'b0, 3'b001, 32'h101, 32'h0);
        mem_rdata = 32'h0;
        #1;
        chk("lh_mask", {28'h0, mem_mask}, 32'h6);
        step();
        mem_rdata = 32'h12F0AB34;
        #1;
        chk("lh_rdata", rsp_rdata, 32'hFFFFF0AB);
        step();

        // SH 0x103 crossing store
        drive(1'b1, 1'b1, 3'b001, 32'h103, 32'h0000ABCD);
        mem_rdata = 32'h0;
        #1;
        chk("sh1_store", {31'h0, mem_store}, 32'h1);
        chk("sh1_addr",  mem_addr,           32'h100);
        chk("sh1_mask",  {28'h0, mem_mask},  32'h8);
        chk("sh1_wdata", mem_wdata,          32'hCD000000);
        chk("sh1_stall", {31'h0, stall},     32'h1);
        step();
        #1;
        chk("sh2_store", {31'h0, mem_store}, 32'h1);
        chk("sh2_addr",  mem_addr,           32'h104);
        chk("sh2_mask",  {28'h0, mem_mask},  32'h1);
        chk("sh2_wdata", mem_wdata,          32'h000000AB);
        chk("sh2_stall", {31'h0, stall},     32'h0);
        step();
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        chk_idle_port("sh_done");

        // LW 0x102 crossing load
        drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        #1;
        chk("lw1_load",  {31'h0, mem_load}, 32'h1);
        chk("lw1_addr",  mem_addr,          32'h100);
        chk("lw1_mask",  {28'h0, mem_mask}, 32'hC);
        chk("lw1_stall", {31'h0, stall},    32'h1);
        step();
        mem_rdata = 32'h11223344;
        #1;
        chk("lw2_load",  {31'h0, mem_load}, 32'h1);
        chk("lw2_addr",  mem_addr,          32'h104);
        chk("lw2_mask",  {28'h0, mem_mask}, 32'h3);
        chk("lw2_stall", {31'h0, stall},    32'h1);
        chk("lw2_rspv",  {31'h0, rsp_valid},32'h0);
        step();
        mem_rdata = 32'h55667788;
        #1;
        chk("lw_rspv",  {31'h0, rsp_valid}, 32'h1);
        chk("lw_rdata", rsp_rdata,          32'h77881122);
        chk_idle_port("lw_resp");
        step();

        // Reset during SECOND of crossing LW, then aligned LW
        mem_rdata = 32'h0;
        #1;
        chk("lwr_load", {31'h0, mem_load}, 32'h1);
        step();
        rst = 1'b1;
        #1;
        chk_idle_port("lwr_rst");
        chk("lwr_stall", {31'h0, stall},     32'h0);
        chk("lwr_rspv",  {31'h0, rsp_valid}, 32'h0);
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        #1;
        chk("lwa_load",  {31'h0, mem_load}, 32'h1);
        chk("lwa_addr",  mem_addr,          32'h200);
        chk("lwa_mask",  {28'h0, mem_mask}, 32'hF);
        chk("lwa_stall", {31'h0, stall},    32'h1);
        step();
        mem_rdata = 32'hCAFEF00D;
        #1;
        chk("lwa_rspv",  {31'h0, rsp_valid}, 32'h1);
        chk("lwa_rdata", rsp_rdata,          32'hCAFEF00D);
        step();
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        chk("lwa_done_rspv", {31'h0, rsp_valid}, 32'h0);
        chk("lwa_done_rd",   rsp_rdata,          32'h0);

        // Invalid funct3
        drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h12345678);
        #1;
        chk_idle_port("inv_ld");
        chk("inv_ld_stall", {31'h0, stall}, 32'h0);
        step();
        chk("inv_ld_rspv", {31'h0, rsp_valid}, 32'h0);
        drive(1'b1, 1'b1, 3'b111, 32'h103, 32'h12345678);
        #1;
        chk_idle_port("inv_st");
        chk("inv_st_stall", {31'h0, stall}, 32'h0);
        step();
        chk("inv_st_rspv", {31'h0, rsp_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have ports `clk` (input, 1, clock) and `rst` (input, 1, asynchronous, active-high reset); all flops use `clk` rising edge.
REQ-002 SHALL have `req_valid` (input, 1): the MEM stage presents a load/store this cycle.
REQ-003 SHALL have `req_store` (input, 1): 1 = store, 0 = load.
REQ-004 SHALL have `req_funct3` (input, 3): RV32I width/sign code (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101).
REQ-005 SHALL have `req_addr` (input, 32, byte address) and `req_wdata` (input, 32, store data, LSB-aligned).
REQ-006 SHALL have `stall` (output, 1): hold the pipeline, so request inputs stay stable.
REQ-007 SHALL have `rsp_valid` (output, 1) and `rsp_rdata` (output, 32): the extended load result.
REQ-008 SHALL have these memory-port outputs: `mem_load` (1), `mem_store` (1), `mem_mask` (4), `mem_addr` (32, word-aligned, bits[1:0]=0) and `mem_wdata` (32).
REQ-009 SHALL have `mem_rdata` (input, 32): valid the cycle after `mem_load`=1 (1-cycle read latency); writes commit on the `clk` edge of the `mem_store` cycle.

Function
REQ-010 SHALL implement an FSM with states IDLE, SECOND and RESP.
REQ-011 SHALL define o = `req_addr`[1:0]; an access "crosses" when o+size>4 (size 1/2/4 bytes).
REQ-012 IDLE, `req_valid`=1, valid funct3: SHALL issue the low access in the same cycle.
- `mem_addr` = {`req_addr`[31:2],2'b00}.
- `mem_mask` = (size mask << o)[3:0], where the size mask is 0001/0011/1111.
- `mem_wdata` = `req_wdata` << 8*o.
REQ-013 Aligned store SHALL have `stall`=0 and stay in IDLE (zero-wait).
REQ-014 Aligned load SHALL have `stall`=1 and go to RESP.
REQ-015 Crossing access SHALL have `stall`=1 and go to SECOND.
REQ-016 SECOND SHALL issue the high access.
- `mem_addr` = low address + 4.
- `mem_mask` = size mask >> (4-o).
- `mem_wdata` = `req_wdata` >> (32-8*o).
REQ-017 SECOND SHALL capture `mem_rdata` (the low-half data) into an internal register.
REQ-018 SECOND, store: SHALL have `stall`=0 and go to IDLE.
REQ-019 SECOND, load: SHALL have `stall`=1 and go to RESP.
REQ-020 RESP SHALL drive `rsp_valid`=1, `stall`=0 and no memory access, then return to IDLE; RESP SHALL ignore `req_valid` (same instruction still present).
REQ-021 `rsp_rdata` SHALL be formed as follows.
- Build the 64-bit word {hi, lo}, where hi = `mem_rdata` and lo = captured data (crossing), or lo = `mem_rdata` and hi = 0 (aligned).
- Shift right by 8*o.
- Sign-extend (000/001) or zero-extend (100/101/010) to 32 bits.
REQ-022 `rsp_rdata` SHALL be 0 whenever `rsp_valid`=0.
REQ-023 Invalid funct3 (011, 110, 111) SHALL cause no memory access, `stall`=0 and no response.
REQ-024 `mem_load`/`mem_store` SHALL never both be 1.
REQ-025 All memory-port outputs SHALL be 0 in RESP and in IDLE without a valid request.
REQ-026 Memory-port outputs SHALL be combinational from the state and the held request inputs.

Reset
REQ-027 `rst`=1 SHALL force IDLE and clear the captured low data.
REQ-028 During reset, `stall`, `rsp_valid`, `rsp_rdata`, `mem_load`, `mem_store`, `mem_mask`, `mem_addr` and `mem_wdata` SHALL all be 0.
REQ-029 Reset asserted in SECOND or RESP SHALL abandon the access with no further memory cycles; a partially written crossing store is not rolled back.

Structure
REQ-030 Package `lsu_pkg` SHALL hold the funct3 width-code constants, the FSM state enum and the size-to-mask function.
REQ-031 Combinational mask/shift/extend logic SHALL sit in sub-module `lsu_align`; `lsu_ctrl` holds the FSM and capture register.

Verification
REQ-032 SW addr 0x100, data 0xDEADBEEF -> one cycle, mask 1111, mem_addr 0x100, stall=0.
REQ-033 LBU addr 0x103, memory word 0x80FF1234 -> stall 1 cycle, then rsp_valid=1, rsp_rdata 0x00000080. LB at the same address -> rsp_rdata 0xFFFFFF80.
REQ-034 SH addr 0x103, data 0xABCD -> cycle 1: mem_addr 0x100, mask 1000, wdata[31:24]=0xCD; cycle 2: mem_addr 0x104, mask 0001, wdata[7:0]=0xAB; stall=1 then 0.
REQ-035 LW addr 0x102, words 0x11223344 @0x100 and 0x55667788 @0x104 -> two issues, then RESP rsp_rdata 0x77881122.
REQ-036 Reset asserted in SECOND of a crossing LW -> all outputs 0 immediately; after release, an aligned LW completes normally.
REQ-037 funct3=011 with req_valid -> no mem_load/mem_store, stall=0, rsp_valid=0.
